// File: rtl/mem_pkg.sv
// Shared encodings and bus-width helpers for the MEM stage and its load extender.
package mem_pkg;

  localparam logic [2:0] LD_W   = 3'd0;
  localparam logic [2:0] LD_B   = 3'd1;
  localparam logic [2:0] LD_BU  = 3'd2;
  localparam logic [2:0] LD_H   = 3'd3;
  localparam logic [2:0] LD_HU  = 3'd4;
  localparam logic [2:0] LD_WU  = 3'd5;
  localparam logic [2:0] LD_D   = 3'd6;
  localparam logic [2:0] LD_RSV = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // {ld_type, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
  function automatic int ex2mem_wd(input int data_w, input int rf_aw);
    return 3 + 32 + 1 + data_w / 8 + 1 + 1 + rf_aw + data_w;
  endfunction

  // {pc, rf_we, rf_waddr, rf_wdata}
  function automatic int mem2wb_wd(input int data_w, input int rf_aw);
    return 32 + 1 + rf_aw + data_w;
  endfunction

  // {rf_we, rf_waddr, rf_wdata}
  function automatic int mem2rf_wd(input int data_w, input int rf_aw);
    return 1 + rf_aw + data_w;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load extractor: picks the byte/half/word lane selected by the
// address offset and sign- or zero-extends it to the register width.
module load_ext
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [OFF_W-1:0]  off,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] data
);

  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [7:0]       b8;
  logic [15:0]      h16;
  logic [31:0]      w32;

  // Halfword and word lanes ignore the low offset bits; misalignment never reaches here.
  assign off_h = off & ~OFF_W'(1);
  assign off_w = off & ~OFF_W'(3);

  assign b8  = 8'(raw >> {off, 3'b000});
  assign h16 = 16'(raw >> {off_h, 3'b000});
  assign w32 = 32'(raw >> {off_w, 3'b000});

  always_comb begin
    data = DATA_W'($signed(w32));
    case (ld_type)
      LD_B:  data = DATA_W'($signed(b8));
      LD_BU: data = DATA_W'(b8);
      LD_H:  data = DATA_W'($signed(h16));
      LD_HU: data = DATA_W'(h16);
      LD_WU: if (DATA_W == 64) data = DATA_W'(w32);
      LD_D:  if (DATA_W == 64) data = raw;
      LD_W, LD_RSV: data = DATA_W'($signed(w32));
      default: data = DATA_W'($signed(w32));
    endcase
  end

endmodule

// File: rtl/mem_stage_ls.sv
// MEM pipeline stage: latches the EX->MEM bus, completes variable-latency loads
// and drives the WB bus and the ID forwarding bus.
module mem_stage_ls
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_AW     = 5,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [STALL_W-1:0]                  stall,
  input  logic                                flush,
  input  logic [ex2mem_wd(DATA_W, RF_AW)-1:0] ex_to_mem_bus,
  input  logic [DATA_W-1:0]                   data_sram_rdata,
  input  logic                                data_sram_rvalid,
  output logic                                stallreq_mem,
  output logic [mem2wb_wd(DATA_W, RF_AW)-1:0] mem_to_wb_bus,
  output logic [mem2rf_wd(DATA_W, RF_AW)-1:0] mem_to_rf_bus
);

  localparam int EX2MEM_WD = ex2mem_wd(DATA_W, RF_AW);
  localparam int WEN_W     = DATA_W / 8;
  localparam int OFF_W     = $clog2(WEN_W);
  localparam int SEL_POS   = DATA_W + RF_AW + 1;
  localparam int WEN_POS   = SEL_POS + 1;
  localparam int EN_POS    = WEN_POS + WEN_W;

  logic [EX2MEM_WD-1:0] ex_r;
  logic [EX2MEM_WD-1:0] ex_nxt;
  logic                 upd;
  logic                 nxt_is_ld;

  logic [2:0]        ld_type;
  logic [31:0]       pc;
  logic              ram_en;
  logic [WEN_W-1:0]  ram_wen;
  logic              sel_rf_res;
  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0] ex_result;

  mem_state_e        state;
  mem_state_e        state_nxt;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we_out;
  logic              is_ld;
  logic              unused_stall;

  assign unused_stall = ^stall;

  assign {ld_type, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = ex_r;
  assign is_ld = ram_en & (ram_wen == '0) & sel_rf_res;

  // Pipeline register update: flush beats bubble beats advance; otherwise hold.
  always_comb begin
    ex_nxt = ex_r;
    upd    = 1'b0;
    if (flush) begin
      ex_nxt = '0;
      upd    = 1'b1;
    end else if (stall[STAGE_IDX] == STOP && stall[STAGE_IDX+1] == NO_STOP) begin
      ex_nxt = '0;
      upd    = 1'b1;
    end else if (stall[STAGE_IDX] == NO_STOP) begin
      ex_nxt = ex_to_mem_bus;
      upd    = 1'b1;
    end
  end

  assign nxt_is_ld = ex_nxt[EN_POS] & (ex_nxt[WEN_POS +: WEN_W] == '0) & ex_nxt[SEL_POS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_r <= '0;
    else     ex_r <= ex_nxt;
  end

  // Memory returns exactly one single-cycle rvalid pulse per issued read, in order;
  // there is no ready, so every response must be consumed or dropped on arrival.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (upd) state_nxt = nxt_is_ld ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (data_sram_rvalid) begin
          if (upd) state_nxt = nxt_is_ld ? ST_WAIT : ST_IDLE;
          else     state_nxt = ST_HOLD;
        end else if (upd) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (data_sram_rvalid) state_nxt = nxt_is_ld ? ST_WAIT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      rd_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && data_sram_rvalid) rd_q <= data_sram_rdata;
    end
  end

  // Same-cycle response is bypassed so zero-wait memory never stalls.
  assign raw = (state == ST_WAIT && data_sram_rvalid) ? data_sram_rdata : rd_q;

  load_ext #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_ext (
    .raw     (raw),
    .off     (ex_result[OFF_W-1:0]),
    .ld_type (ld_type),
    .data    (ld_data)
  );

  assign stallreq_mem = is_ld & (((state == ST_WAIT) & ~data_sram_rvalid) | (state == ST_DRAIN));

  // Suppress the write while waiting so ID never forwards a stale value.
  assign rf_we_out = rf_we & ~stallreq_mem;
  assign rf_wdata  = is_ld ? ld_data : ex_result;

  assign mem_to_wb_bus = {pc, rf_we_out, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {rf_we_out, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls: zero-wait and late loads, flush/drain,
// stall bubble/hold, store pass-through and asynchronous reset mid-load.
module tb_mem_stage_ls;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [78:0] bus;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stallreq;
  logic [69:0] wb_bus;
  logic [37:0] rf_bus;

  int vectors;
  int miscompares;
  bit stray_ok;

  wire [31:0] wb_pc    = wb_bus[69:38];
  wire        wb_we    = wb_bus[37];
  wire [4:0]  wb_waddr = wb_bus[36:32];
  wire [31:0] wb_wdata = wb_bus[31:0];

  mem_stage_ls dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .ex_to_mem_bus    (bus),
    .data_sram_rdata  (rdata),
    .data_sram_rvalid (rvalid),
    .stallreq_mem     (stallreq),
    .mem_to_wb_bus    (wb_bus),
    .mem_to_rf_bus    (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A response while nothing is outstanding is a memory protocol error.
  always @(posedge clk) begin
    if (!rst && rvalid && !stray_ok && (dut.state == ST_IDLE || dut.state == ST_HOLD)) begin
      miscompares++;
      $display("FAIL protocol: rvalid seen with state %0d, required none outstanding", dut.state);
    end
  end

  function automatic logic [78:0] op(input logic [2:0] lt, input logic [31:0] pc, input logic en,
                                     input logic [3:0] wen, input logic sel, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {lt, pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [78:0] ld(input logic [2:0] lt, input logic [31:0] pc,
                                     input logic [4:0] wa, input logic [31:0] res);
    return op(lt, pc, 1'b1, 4'h0, 1'b1, 1'b1, wa, res);
  endfunction

  task automatic drive(input logic [78:0] b, input logic [5:0] s, input logic f,
                       input logic v, input logic [31:0] d);
    @(negedge clk);
    bus = b; stall = s; flush = f; rvalid = v; rdata = d;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; stall = '0; flush = 1'b0; bus = '0; rvalid = 1'b0; rdata = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL reset_stallreq: got %b want 0", stallreq); end
    vectors++; if (wb_bus !== 70'd0) begin miscompares++; $display("FAIL reset_wb: got %h want 0", wb_bus); end
    vectors++; if (rf_bus !== 38'd0) begin miscompares++; $display("FAIL reset_rf: got %h want 0", rf_bus); end
    vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lb_zero_wait;
    drive(ld(LD_B, 32'h100, 5'd1, 32'h1003), 6'b0, 1'b0, 1'b0, 32'h0);
    drive(op(LD_W, 32'h104, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h55), 6'b0, 1'b0, 1'b1, 32'h80FF_0000);
    vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL lb_stallreq: got %b want 0", stallreq); end
    vectors++; if (wb_wdata !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_wdata: got %h want ffffff80", wb_wdata); end
    vectors++; if (wb_we !== 1'b1 || wb_pc !== 32'h100) begin miscompares++; $display("FAIL lb_we_pc: got %b %h want 1 00000100", wb_we, wb_pc); end
    vectors++; if (rf_bus !== {1'b1, 5'd1, 32'hFFFF_FF80}) begin miscompares++; $display("FAIL lb_rf_bus: got %h want %h", rf_bus, {1'b1, 5'd1, 32'hFFFF_FF80}); end
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_bus !== {32'h104, 1'b1, 5'd2, 32'h55}) begin miscompares++; $display("FAIL alu_pass: got %h want %h", wb_bus, {32'h104, 1'b1, 5'd2, 32'h55}); end
  endtask

  task automatic test_back_to_back;
    drive(ld(LD_HU, 32'h200, 5'd3, 32'h2002), 6'b0, 1'b0, 1'b0, 32'h0);
    drive(ld(LD_H, 32'h204, 5'd4, 32'h2002), 6'b0, 1'b0, 1'b1, 32'h8001_1234);
    vectors++; if (wb_wdata !== 32'h0000_8001 || wb_we !== 1'b1) begin miscompares++; $display("FAIL lhu: got %h we %b want 00008001 we 1", wb_wdata, wb_we); end
    drive('0, 6'b0, 1'b0, 1'b1, 32'h8001_1234);
    vectors++; if (wb_wdata !== 32'hFFFF_8001 || wb_waddr !== 5'd4) begin miscompares++; $display("FAIL lh: got %h wa %0d want ffff8001 wa 4", wb_wdata, wb_waddr); end
    vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL lh_stallreq: got %b want 0", stallreq); end
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_bus !== 70'd0) begin miscompares++; $display("FAIL lh_empty: got %h want 0", wb_bus); end
  endtask

  task automatic test_lw_late;
    drive(ld(LD_W, 32'h300, 5'd5, 32'h3000), 6'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive('0, 6'b011111, 1'b0, 1'b0, 32'h0);
      vectors++; if (stallreq !== 1'b1) begin miscompares++; $display("FAIL lw_wait_stallreq[%0d]: got %b want 1", i, stallreq); end
      vectors++; if (wb_we !== 1'b0 || rf_bus[37] !== 1'b0) begin miscompares++; $display("FAIL lw_wait_we[%0d]: got %b %b want 0 0", i, wb_we, rf_bus[37]); end
    end
    drive('0, 6'b011111, 1'b0, 1'b1, 32'hCAFE_F00D);
    vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL lw_arrive_stallreq: got %b want 0", stallreq); end
    vectors++; if (wb_bus !== {32'h300, 1'b1, 5'd5, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL lw_arrive: got %h want %h", wb_bus, {32'h300, 1'b1, 5'd5, 32'hCAFE_F00D}); end
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_wdata !== 32'hCAFE_F00D || wb_we !== 1'b1 || stallreq !== 1'b0) begin miscompares++; $display("FAIL lw_hold: got %h we %b sr %b want cafef00d 1 0", wb_wdata, wb_we, stallreq); end
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_bus !== 70'd0) begin miscompares++; $display("FAIL lw_empty: got %h want 0", wb_bus); end
  endtask

  task automatic test_flush_drain;
    drive(ld(LD_W, 32'h400, 5'd6, 32'h3004), 6'b0, 1'b0, 1'b0, 32'h0);
    drive('0, 6'b011111, 1'b1, 1'b0, 32'h0);
    vectors++; if (stallreq !== 1'b1) begin miscompares++; $display("FAIL fl_wait: got %b want 1", stallreq); end
    drive(ld(LD_W, 32'h404, 5'd7, 32'h3008), 6'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (stallreq !== 1'b0 || wb_bus !== 70'd0) begin miscompares++; $display("FAIL fl_squash: got sr %b bus %h want 0 0", stallreq, wb_bus); end
    drive('0, 6'b011111, 1'b0, 1'b1, 32'h0000_DEAD);
    vectors++; if (stallreq !== 1'b1 || wb_we !== 1'b0) begin miscompares++; $display("FAIL fl_drop: got sr %b we %b want 1 0", stallreq, wb_we); end
    drive('0, 6'b011111, 1'b0, 1'b1, 32'h0000_1234);
    vectors++; if (wb_bus !== {32'h404, 1'b1, 5'd7, 32'h0000_1234} || stallreq !== 1'b0) begin miscompares++; $display("FAIL fl_second: got %h sr %b want %h sr 0", wb_bus, stallreq, {32'h404, 1'b1, 5'd7, 32'h0000_1234}); end
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_wdata !== 32'h0000_1234) begin miscompares++; $display("FAIL fl_hold: got %h want 00001234", wb_wdata); end
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_stall_bubble;
    drive(op(LD_W, 32'h500, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h77), 6'b0, 1'b0, 1'b0, 32'h0);
    drive(op(LD_W, 32'h504, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h88), 6'b011111, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_bus !== {32'h500, 1'b1, 5'd8, 32'h77}) begin miscompares++; $display("FAIL st_first: got %h want %h", wb_bus, {32'h500, 1'b1, 5'd8, 32'h77}); end
    drive(op(LD_W, 32'h504, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h88), 6'b001111, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_bus !== {32'h500, 1'b1, 5'd8, 32'h77}) begin miscompares++; $display("FAIL st_hold: got %h want %h", wb_bus, {32'h500, 1'b1, 5'd8, 32'h77}); end
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_bus !== 70'd0) begin miscompares++; $display("FAIL st_bubble: got %h want 0", wb_bus); end
  endtask

  task automatic test_store;
    drive(op(LD_W, 32'h600, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h6000), 6'b0, 1'b0, 1'b0, 32'h0);
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (wb_bus !== {32'h600, 1'b0, 5'd0, 32'h6000} || stallreq !== 1'b0) begin miscompares++; $display("FAIL store: got %h sr %b want %h sr 0", wb_bus, stallreq, {32'h600, 1'b0, 5'd0, 32'h6000}); end
    vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL store_state: got %0d want %0d", dut.state, ST_IDLE); end
  endtask

  task automatic test_reset_mid_wait;
    drive(ld(LD_W, 32'h700, 5'd3, 32'h10), 6'b0, 1'b0, 1'b0, 32'h0);
    drive('0, 6'b011111, 1'b0, 1'b0, 32'h0);
    vectors++; if (stallreq !== 1'b1) begin miscompares++; $display("FAIL rw_wait: got %b want 1", stallreq); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (wb_bus !== 70'd0 || rf_bus !== 38'd0 || stallreq !== 1'b0) begin miscompares++; $display("FAIL rw_async: got %h %h sr %b want 0 0 0", wb_bus, rf_bus, stallreq); end
    vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL rw_state: got %0d want %0d", dut.state, ST_IDLE); end
    @(negedge clk);
    rst = 1'b0;
    stray_ok = 1'b1;
    drive('0, 6'b0, 1'b0, 1'b1, 32'h0000_0BAD);
    vectors++; if (wb_bus !== 70'd0 || stallreq !== 1'b0) begin miscompares++; $display("FAIL rw_late: got %h sr %b want 0 0", wb_bus, stallreq); end
    drive('0, 6'b0, 1'b0, 1'b0, 32'h0);
    stray_ok = 1'b0;
    vectors++; if (dut.state !== ST_IDLE || wb_bus !== 70'd0) begin miscompares++; $display("FAIL rw_after: got state %0d bus %h want %0d 0", dut.state, wb_bus, ST_IDLE); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    stray_ok = 1'b0;
    test_reset;
    test_lb_zero_wait;
    test_back_to_back;
    test_lw_late;
    test_flush_drain;
    test_stall_bubble;
    test_store;
    test_reset_mid_wait;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
